apb_master_bridge: RTL

- APB initiator that converts a simple single-outstanding request/response interface from the RISC-V core's data bus into APB transfers.
- Decodes the address to one of NUM_SLV peripheral selects, for example the FIFO/UART, GPIO or timer slaves.
- Runs the SETUP/ACCESS sequence, waits for the selected slave's PREADY, and returns read data.
- Reports an error for unmapped addresses and for slaves that stall past a timeout.

---
 rtl/apb_master_bridge.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB initiator: turns single-outstanding core requests into APB SETUP/ACCESS
// transfers to one of NUM_SLV peripherals. Unmapped addresses and slaves that
// stall past TIMEOUT access cycles produce an error response.
module apb_master_bridge #(
  parameter int unsigned NUM_SLV = 4,
  parameter logic [15:0] BASE_HI = 16'h1000,
  parameter int unsigned SEL_LSB = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [31:0]            PADDR,
  output logic [31:0]            PWDATA,
  output logic                   PWRITE,
  output logic                   PENABLE,
  output logic [NUM_SLV-1:0]     PSEL,
  input  logic [32*NUM_SLV-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]     PREADY
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e               state_q, state_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [31:0]          paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [3:0]           idx;
  logic                 hit;
  logic [NUM_SLV-1:0]   dec_sel;
  logic                 sel_ready;
  logic [31:0]          sel_rdata;

  assign idx = req_addr[SEL_LSB +: 4];

  // Address decode and selected-slave muxing; the latched one-hot PSEL picks
  // the slave, so unselected PREADY/PRDATA never reach the datapath.
  always_comb begin
    hit       = (req_addr[31:16] == BASE_HI) && (32'(idx) < NUM_SLV);
    dec_sel   = '0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      dec_sel[i] = (idx == 4'(i));
      if (psel_q[i]) sel_rdata = sel_rdata | PRDATA[32*i +: 32];
    end
    sel_ready = |(PREADY & psel_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (hit) begin
            state_d  = StSetup;
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
            pwrite_d = req_write;
            psel_d   = dec_sel;
            cnt_d    = '0;
          end else begin
            // Unmapped: answer straight away, never touch the APB side.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (sel_ready) begin
          state_d     = StResp;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? 32'h0 : sel_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = StResp;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a response.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q     <= StIdle;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
